// File: rtl/alu32_arbiter.sv
// ============================================================================
// Module      : alu32_arbiter
// Description : Round-robin sharing of one alu32 datapath between two
//               requesters, with a tagged single response channel.
//               Optional macro ALU_OPCHK_EN: illegal opcodes bypass the ALU
//               and return an error response.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu32_arbiter #(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_d,
  input  logic             alu_cout,
  input  logic             alu_v,
  input  logic             alu_z,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_d,
  output logic [2:0]       rsp_flags,
  output logic             rsp_err,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] c_CNT_INIT = 4'(ALU_LAT - 1);

  state_t           r_state;
  state_t           w_next;
  logic             r_ptr;
  logic             r_id;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_d;
  logic [2:0]       r_flags;

  logic             w_gnt;
  logic             w_accept;
  logic             w_bad;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [2:0]       w_sel_op;

  // Pointer's requester wins if it is asking; otherwise the other one.
  assign w_gnt    = req_valid[r_ptr] ? r_ptr : ~r_ptr;
  assign w_sel_a  = w_gnt ? req1_a  : req0_a;
  assign w_sel_b  = w_gnt ? req1_b  : req0_b;
  assign w_sel_op = w_gnt ? req1_op : req0_op;

`ifdef ALU_OPCHK_EN
  logic r_err;
  assign w_bad   = !((w_sel_op == 3'b000) || (w_sel_op == 3'b001) || (w_sel_op == 3'b111));
  assign rsp_err = r_err;
`else
  assign w_bad   = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    req_ready = 2'b00;
    case (r_state)
      S_IDLE: begin
        // Gated by reset_n so nothing is accepted on an edge that resets.
        if ((|req_valid) && reset_n) begin
          w_accept  = 1'b1;
          req_ready = w_gnt ? 2'b10 : 2'b01;
          w_next    = w_bad ? S_RESP : S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_cnt == 4'd0) w_next = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_ptr   <= 1'b0;
      r_id    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= 3'b000;
      r_cnt   <= 4'd0;
      r_d     <= '0;
      r_flags <= 3'b000;
`ifdef ALU_OPCHK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_id <= w_gnt;
        if (!w_bad) begin
          r_a   <= w_sel_a;
          r_b   <= w_sel_b;
          r_op  <= w_sel_op;
          r_cnt <= c_CNT_INIT;
        end
`ifdef ALU_OPCHK_EN
        r_err <= w_bad;
        if (w_bad) begin
          r_d     <= '0;
          r_flags <= 3'b000;
        end
`endif
      end
      if (r_state == S_EXEC) begin
        if (r_cnt == 4'd0) begin
          r_d     <= alu_d;
          r_flags <= {alu_cout, alu_v, alu_z};
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
      // The requester that just lost gets priority next time.
      if ((r_state == S_RESP) && rsp_ready) r_ptr <= ~r_id;
    end
  end

  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_op    = r_op;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_id    = r_id;
  assign rsp_d     = r_d;
  assign rsp_flags = r_flags;
  assign busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu32_arbiter.sv
// ============================================================================
// Module      : tb_alu32_arbiter
// Description : Directed self-checking bench for alu32_arbiter with a
//               behavioural alu32 model. Honours ALU_OPCHK_EN if defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu32_arbiter;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic [31:0] alu_a, alu_b, alu_d;
  logic [2:0]  alu_op;
  logic        alu_cout, alu_v, alu_z;
  logic        rsp_valid, rsp_id, rsp_err, busy;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_d;
  logic [2:0]  rsp_flags;

  int n_checks = 0;
  int n_errors = 0;

  alu32_arbiter #(.WIDTH(32), .ALU_LAT(LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_d(alu_d), .alu_cout(alu_cout), .alu_v(alu_v), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_d(rsp_d), .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural alu32: add, shift-left, and.
  always_comb begin
    alu_d    = '0;
    alu_cout = 1'b0;
    alu_v    = 1'b0;
    case (alu_op)
      3'b000: begin
        {alu_cout, alu_d} = {1'b0, alu_a} + {1'b0, alu_b};
        alu_v = (alu_a[31] == alu_b[31]) && (alu_d[31] != alu_a[31]);
      end
      3'b001: alu_d = alu_a << alu_b[4:0];
      3'b111: alu_d = alu_a & alu_b;
      default: alu_d = '0;
    endcase
    alu_z = (alu_d == '0);
  end

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] d;
    logic [2:0]  f;
    logic [2:0]  m;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic drive(input logic id, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    if (id) begin req1_a = a; req1_b = b; req1_op = op; end
    else    begin req0_a = a; req0_b = b; req0_op = op; end
  endtask

  // Counts negedges after the accept edge until rsp_valid, bounded.
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 40);
  endtask

  task automatic run_op(input string tag, input logic id, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input logic [31:0] ed, input logic [2:0] ef,
                        input logic [2:0] em, input int exp_lat, input logic exp_err);
    int lat;
    @(negedge clk);
    drive(id, a, b, op);
    req_valid = id ? 2'b10 : 2'b01;
    #1 check({tag, " ready"}, req_ready, id ? 2'b10 : 2'b01);
    @(posedge clk);
    #1 req_valid = 2'b00;
    wait_rsp(lat);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " id"}, rsp_id, id);
    check({tag, " d"}, rsp_d, ed);
    check({tag, " flags"}, rsp_flags & em, ef & em);
    check({tag, " err"}, rsp_err, exp_err);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bad_wait;
    int lat;
    logic [31:0] hold_d;

    vecs[0] = '{1'b0, 32'd7,        32'd5,        3'b000, 32'd12,       3'b000, 3'b111};
    vecs[1] = '{1'b1, 32'h7FFFFFFF, 32'd1,        3'b000, 32'h80000000, 3'b010, 3'b111};
    vecs[2] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b111, 32'hFFFFFFFF, 3'b000, 3'b001};
    vecs[3] = '{1'b0, 32'hFFFFFFFF, 32'd1,        3'b000, 32'h00000000, 3'b101, 3'b111};
    vecs[4] = '{1'b0, 32'h80000000, 32'h80000000, 3'b000, 32'h00000000, 3'b111, 3'b111};
    vecs[5] = '{1'b1, 32'd1,        32'd4,        3'b001, 32'd16,       3'b000, 3'b001};
    vecs[6] = '{1'b0, 32'h0000F0F0, 32'h00000FF0, 3'b111, 32'h000000F0, 3'b000, 3'b001};
    vecs[7] = '{1'b1, 32'd1,        32'd31,       3'b001, 32'h80000000, 3'b000, 3'b001};

    // Reset state
    do_reset();
    @(negedge clk);
    check("reset outputs",
          {req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_d, rsp_flags, rsp_err, busy}, '0);

    // Single-requester vectors
    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].op,
             vecs[i].d, vecs[i].f, vecs[i].m, LAT + 1, 1'b0);

    // Simultaneous requests: 0 first, 1 waits, grants spaced LAT+2 cycles
    do_reset();
    @(negedge clk);
    drive(1'b0, 32'd3, 32'd4, 3'b000);
    drive(1'b1, 32'd1, 32'd4, 3'b001);
    req_valid = 2'b11;
    #1 check("sim grant0", req_ready, 2'b01);
    @(posedge clk);
    #1 req_valid = 2'b10;
    bad_wait = 0;
    for (int c = 1; c <= LAT + 2; c++) begin
      @(negedge clk);
      #1;
      if (c <= LAT + 1 && req_ready !== 2'b00) bad_wait++;
      if (c == LAT + 1) begin
        check("sim rsp0 valid", rsp_valid, 1'b1);
        check("sim rsp0 id", rsp_id, 1'b0);
        check("sim rsp0 d", rsp_d, 32'd7);
      end
      if (c == LAT + 2) check("sim grant1", req_ready, 2'b10);
    end
    check("sim req1 held off", bad_wait, 0);
    @(posedge clk);
    #1 req_valid = 2'b00;
    wait_rsp(lat);
    check("sim rsp1 latency", lat, LAT + 1);
    check("sim rsp1 id", rsp_id, 1'b1);
    check("sim rsp1 d", rsp_d, 32'd16);
    @(posedge clk);
    #1;

    // Back-pressure in RESP with both requesting
    do_reset();
    @(negedge clk);
    rsp_ready = 1'b0;
    drive(1'b0, 32'd2, 32'd3, 3'b000);
    drive(1'b1, 32'd10, 32'd20, 3'b000);
    req_valid = 2'b11;
    #1 check("bp grant0", req_ready, 2'b01);
    @(posedge clk);
    wait_rsp(lat);
    check("bp latency", lat, LAT + 1);
    check("bp d", rsp_d, 32'd5);
    hold_d = rsp_d;
    bad_wait = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_d !== hold_d || rsp_flags !== 3'b000 ||
          req_ready !== 2'b00 || busy !== 1'b1) bad_wait++;
      @(negedge clk);
    end
    check("bp hold stable", bad_wait, 0);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1 check("bp rr grant1", req_ready, 2'b10);
    @(posedge clk);
    #1 req_valid = 2'b00;
    wait_rsp(lat);
    check("bp rsp1 id", rsp_id, 1'b1);
    check("bp rsp1 d", rsp_d, 32'd30);
    @(posedge clk);
    #1;

    // Reset during EXEC
    @(negedge clk);
    drive(1'b0, 32'd9, 32'd9, 3'b000);
    req_valid = 2'b01;
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
    check("exec busy", busy, 1'b1);
    reset_n = 1'b0;
    @(posedge clk);
    #1 check("mid-op reset outputs",
             {req_ready, alu_a, alu_b, alu_op, rsp_valid, rsp_id, rsp_d, rsp_flags, rsp_err, busy}, '0);
    reset_n = 1'b1;
    bad_wait = 0;
    for (int c = 0; c < LAT + 3; c++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) bad_wait++;
    end
    check("no rsp after reset", bad_wait, 0);
    run_op("post-reset", 1'b1, 32'd1, 32'd2, 3'b000, 32'd3, 3'b000, 3'b111, LAT + 1, 1'b0);

`ifdef ALU_OPCHK_EN
    // Illegal opcode bypasses the ALU
    run_op("pre-illegal", 1'b0, 32'd1, 32'd1, 3'b001, 32'd2, 3'b000, 3'b001, LAT + 1, 1'b0);
    run_op("illegal", 1'b0, 32'd5, 32'd6, 3'b010, 32'd0, 3'b000, 3'b111, 1, 1'b1);
    check("illegal alu_op kept", alu_op, 3'b001);
    check("illegal alu_a kept", alu_a, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
